// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential imem requests, in-order prefetch queue, redirect flush.
// Optional build macro IFU_PERF_CNT_EN adds perf_delivered / perf_discarded counters.
module instr_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_delivered,
  output logic [31:0] perf_discarded
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake rule on every port pair: a transfer happens on the rising edge
  // where valid and ready are both high; valid never depends on ready.
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_q_data [DEPTH];
  logic [31:0]   r_q_pc   [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_if_pc  [DEPTH];
  logic [PW-1:0] r_if_rd;
  logic [PW-1:0] r_if_wr;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_discard;

  logic [CW+1:0] w_credit_sum;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_rsp_keep;
  logic          w_push;
  logic          w_instr_valid;
  logic          w_pop;

  // Every accepted request reserves a queue slot until its response lands or is dropped.
  assign w_credit_sum  = (CW+2)'(r_count) + (CW+2)'(r_inflight) + (CW+2)'(r_discard);
  assign w_req_valid   = !rst && !redirect_valid && (w_credit_sum < (CW+2)'(DEPTH));
  assign w_req_fire    = w_req_valid && imem_req_ready;
  assign w_rsp_keep    = imem_rsp_valid && (r_discard == '0);
  assign w_push        = w_rsp_keep && !redirect_valid;
  assign w_instr_valid = (r_count != '0);
  assign w_pop         = w_instr_valid && instr_ready;

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign instr_valid    = w_instr_valid;
  assign instr_data     = w_instr_valid ? r_q_data[r_rd_ptr] : 32'h0;
  assign instr_pc       = w_instr_valid ? r_q_pc[r_rd_ptr]   : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC & 32'hFFFF_FFFC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_if_rd    <= '0;
      r_if_wr    <= '0;
      r_inflight <= '0;
      r_discard  <= '0;
    end else if (redirect_valid) begin
      // Any response arriving now is dropped, whether or not it was already marked.
      r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_if_rd    <= '0;
      r_if_wr    <= '0;
      r_inflight <= '0;
      r_discard  <= r_discard + r_inflight - CW'(imem_rsp_valid);
    end else begin
      if (w_req_fire) begin
        r_if_wr    <= r_if_wr + PW'(1);
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (imem_rsp_valid && (r_discard != '0)) begin
        r_discard <= r_discard - CW'(1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        r_if_rd  <= r_if_rd + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_push);
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_if_pc[r_if_wr] <= r_fetch_pc;
    end
    if (w_push) begin
      r_q_data[r_wr_ptr] <= imem_rsp_data;
      r_q_pc[r_wr_ptr]   <= r_if_pc[r_if_rd];
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] w_flushed;
  logic        w_rsp_drop;

  // The entry popped during a redirect is delivered, so it is not counted as flushed.
  assign w_flushed  = redirect_valid ? 32'(r_count - CW'(w_pop)) : 32'h0;
  assign w_rsp_drop = imem_rsp_valid && (redirect_valid || (r_discard != '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_delivered <= 32'h0;
      perf_discarded <= 32'h0;
    end else begin
      perf_delivered <= perf_delivered + 32'(w_pop);
      perf_discarded <= perf_discarded + w_flushed + 32'(w_rsp_drop);
    end
  end
`endif

  a_rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> ((r_inflight != '0) || (r_discard != '0)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: latency-configurable memory model, expected-queue scoreboard.
// Build with IFU_PERF_CNT_EN defined to also check the perf counters.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_delivered;
  logic [31:0] perf_discarded;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mem_lat  = 1;

  logic [63:0] exp_q[$];
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  logic [31:0] acc_q[$];
  int          acc_cyc_q[$];
  int          pop_cyc_q[$];

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_delivered (perf_delivered),
    .perf_discarded (perf_discarded)
`endif
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({mem_word(pc), pc});
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    acc_q.delete();
    acc_cyc_q.delete();
    pop_cyc_q.delete();
  endtask

  task automatic drain(input int n, input string name);
    repeat (n) @(negedge clk);
    #1;
    check32(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_acc(input int idx, input logic [31:0] addr, input string name);
    check32(name, (idx < acc_q.size()) ? acc_q[idx] : 32'hDEAD_DEAD, addr);
  endtask

  // ---------------- memory model (driver) ----------------
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        mem_addr_q.delete();
        mem_due_q.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end else if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_addr_q.pop_front());
        void'(mem_due_q.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
      #2;
      if (!rst && imem_req_valid && imem_req_ready) begin
        mem_addr_q.push_back(imem_req_addr);
        mem_due_q.push_back(cyc + mem_lat);
        acc_q.push_back(imem_req_addr);
        acc_cyc_q.push_back(cyc);
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && instr_valid && instr_ready) begin
        pop_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got pc 0x%08h expected no delivery", instr_pc);
        end else begin
          e = exp_q.pop_front();
          check32("pop_pc", instr_pc, e[31:0]);
          check32("pop_data", instr_data, e[63:32]);
        end
      end
    end
  end

  // ---------------- directed scenarios ----------------
  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check32("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check32("rst_instr_valid", 32'(instr_valid), 32'd0);
    check32("rst_instr_data", instr_data, 32'h0);
    check32("rst_instr_pc", instr_pc, 32'h0);

    // Streaming at one per cycle with latency-1 memory.
    do_reset();
    mem_lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b1;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
    repeat (4) @(negedge clk);
    imem_req_ready = 1'b0;
    drain(8, "t1_drain");
    check32("t1_acc_count", 32'(acc_q.size()), 32'd4);
    check32("t1_pop_count", 32'(pop_cyc_q.size()), 32'd4);
    for (int i = 0; i < pop_cyc_q.size() && i < 4 && acc_cyc_q.size() > 0; i++)
      check32("t1_pop_cycle", 32'(pop_cyc_q[i] - acc_cyc_q[0]), 32'(2 + i));
`ifdef IFU_PERF_CNT_EN
    check32("t1_perf_delivered", perf_delivered, 32'd4);
    check32("t1_perf_discarded", perf_discarded, 32'd0);
`endif

    // Back-pressure: exactly DEPTH requests, then drain and resume at 0x10.
    do_reset();
    mem_lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check32("t2_acc_count", 32'(acc_q.size()), 32'd4);
    check_acc(0, 32'h0, "t2_acc0");
    check_acc(3, 32'hC, "t2_acc3");
    check32("t2_req_stalled", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    instr_ready = 1'b1; imem_req_ready = 1'b0;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
    repeat (6) @(negedge clk);
    #1;
    check32("t2_resume_valid", 32'(imem_req_valid), 32'd1);
    check32("t2_resume_addr", imem_req_addr, 32'h10);
    @(negedge clk);
    imem_req_ready = 1'b1;
    push_exp(32'h10);
    @(negedge clk);
    imem_req_ready = 1'b0;
    drain(6, "t2_drain");
    check_acc(4, 32'h10, "t2_acc4");

    // Redirect with two requests in flight at latency 3.
    do_reset();
    mem_lat = 3; imem_req_ready = 1'b1; instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h103;
    #1;
    check32("t3_req_blocked", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    push_exp(32'h100);
    #1;
    check32("t3_instr_invalid", 32'(instr_valid), 32'd0);
    check32("t3_new_addr", imem_req_addr, 32'h100);
    @(negedge clk);
    imem_req_ready = 1'b0;
    drain(8, "t3_drain");
    check32("t3_acc_count", 32'(acc_q.size()), 32'd3);
`ifdef IFU_PERF_CNT_EN
    check32("t3_perf_delivered", perf_delivered, 32'd1);
    check32("t3_perf_discarded", perf_discarded, 32'd2);
`endif

    // Redirect coinciding with an arriving response and a pop.
    do_reset();
    mem_lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b0;
    push_exp(32'h0);
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h200; instr_ready = 1'b1;
    #1;
    check32("t4_head_valid", 32'(instr_valid), 32'd1);
    check32("t4_rsp_present", 32'(imem_rsp_valid), 32'd1);
    @(negedge clk);
    redirect_valid = 1'b0;
    push_exp(32'h200);
    #1;
    check32("t4_queue_empty", 32'(instr_valid), 32'd0);
    check32("t4_new_addr", imem_req_addr, 32'h200);
    @(negedge clk);
    imem_req_ready = 1'b0;
    drain(6, "t4_drain");
    check32("t4_acc_count", 32'(acc_q.size()), 32'd4);
`ifdef IFU_PERF_CNT_EN
    check32("t4_perf_delivered", perf_delivered, 32'd2);
    check32("t4_perf_discarded", perf_discarded, 32'd2);
`endif

    // Fetch address wraps from the top of the address space.
    do_reset();
    mem_lat = 1; imem_req_ready = 1'b0; instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    @(negedge clk);
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    push_exp(32'hFFFF_FFFC); push_exp(32'h0);
    #1;
    check32("t5_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    #1;
    check32("t5_addr_wrap", imem_req_addr, 32'h0);
    @(negedge clk);
    imem_req_ready = 1'b0;
    drain(6, "t5_drain");

    // Asynchronous reset mid-burst with three requests outstanding.
    do_reset();
    mem_lat = 3; imem_req_ready = 1'b1; instr_ready = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check32("t6_pre_valid", 32'(instr_valid), 32'd1);
    check32("t6_pre_data", instr_data, mem_word(32'h0));
    #2;
    rst = 1'b1;
    #1;
    check32("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
    check32("t6_rst_instr_valid", 32'(instr_valid), 32'd0);
    check32("t6_rst_instr_data", instr_data, 32'h0);
    check32("t6_rst_instr_pc", instr_pc, 32'h0);
`ifdef IFU_PERF_CNT_EN
    check32("t6_perf_delivered", perf_delivered, 32'd0);
    check32("t6_perf_discarded", perf_discarded, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0; mem_lat = 1; instr_ready = 1'b1;
    acc_q.delete(); acc_cyc_q.delete(); pop_cyc_q.delete();
    push_exp(32'h0);
    #1;
    check32("t6_restart_valid", 32'(imem_req_valid), 32'd1);
    check32("t6_restart_addr", imem_req_addr, 32'h0);
    @(negedge clk);
    imem_req_ready = 1'b0;
    drain(6, "t6_drain");
    check32("t6_acc_count", 32'(acc_q.size()), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
